// File: rtl/myip23_arb_pkg.sv
// Shared types and constants for the myip23 buffer-RAM arbiter.
// Optional beat limit per grant is enabled by defining MEM_ARB_BURST_LIMIT_EN.
package myip23_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_DEF = 3;
    localparam int ID_W        = $clog2(NUM_REQ_DEF);
    localparam int MAX_RD_LAT  = 4;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/myip23_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Returns one-hot grant, its index, and whether anything was requesting.
module myip23_rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // scan from ptr upward, wrapping, and stop at the first hit
    always_comb begin
        int c;
        c   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!any && req[c]) begin
                any    = 1'b1;
                gnt[c] = 1'b1;
                idx    = IW'(c);
            end
        end
    end

endmodule

// File: rtl/myip23_mem_arbiter.sv
// Burst-granular round-robin arbiter for the myip23 single-port buffer RAM.
// Define MEM_ARB_BURST_LIMIT_EN to force-end bursts after MAX_BEATS beats.
module myip23_mem_arbiter
    import myip23_arb_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int MEM_RD_LAT = 1,
    parameter int MAX_BEATS  = 256
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_we,
    input  logic [NUM_REQ-1:0]         req_last,
    input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]         req_gnt,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner_id,
    output logic                       err_burst
);

    localparam int IW  = id_width(NUM_REQ);
    localparam int LAT = (MEM_RD_LAT > MAX_RD_LAT) ? MAX_RD_LAT : MEM_RD_LAT;

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [LAT-1:0] tv_q, tv_d;
    logic [IW-1:0]  tid_q [LAT];
    logic [IW-1:0]  tid_d [LAT];

    logic [NUM_REQ-1:0] pick_oh_unused;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic               acc;
    logic               rd_acc;
    logic               limit_hit;

    myip23_rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_q),
        .gnt (pick_oh_unused),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign acc      = (state_q == ST_BURST) && req_valid[owner_q];
    assign busy     = (state_q == ST_BURST);
    assign owner_id = owner_q;

    // arbitration FSM and zero-latency steering of the owner's beat
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        req_gnt   = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        rd_acc    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d = pick_idx;
                    state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                req_gnt[owner_q] = req_valid[owner_q];
                if (acc) begin
                    mem_en    = 1'b1;
                    mem_we    = req_we[owner_q];
                    mem_addr  = req_addr[int'(owner_q)*ADDR_W +: ADDR_W];
                    mem_wdata = req_wdata[int'(owner_q)*DATA_W +: DATA_W];
                    rd_acc    = !req_we[owner_q];
                    if (req_last[owner_q] || limit_hit) begin
                        state_d = ST_IDLE;
                        rr_d    = (owner_q == IW'(NUM_REQ-1)) ?
                                  '0 : owner_q + IW'(1);
                    end
                end
            end
        endcase
    end

    // read tag shift: {valid, owner} travels alongside the RAM latency
    always_comb begin
        tv_d     = '0;
        tv_d[0]  = rd_acc;
        tid_d[0] = owner_q;
        for (int i = 1; i < LAT; i++) begin
            tv_d[i]  = tv_q[i-1];
            tid_d[i] = tid_q[i-1];
        end
    end

    // route returning read data to the requester that issued it
    always_comb begin
        rsp_valid = '0;
        if (tv_q[LAT-1]) begin
            rsp_valid[tid_q[LAT-1]] = 1'b1;
        end
    end

    assign rsp_rdata = mem_rdata;

    // state, owner, pointer and read-tag registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            tv_q    <= '0;
            for (int i = 0; i < LAT; i++) begin
                tid_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            tv_q    <= tv_d;
            for (int i = 0; i < LAT; i++) begin
                tid_q[i] <= tid_d[i];
            end
        end
    end

`ifdef MEM_ARB_BURST_LIMIT_EN
    localparam int CNT_W = $clog2(MAX_BEATS) + 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // beats accepted in the current grant; the last allowed beat ends it
    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        limit_hit = acc && !req_last[owner_q] &&
                    (cnt_q == CNT_W'(MAX_BEATS - 1));
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
        end else if (acc) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (limit_hit) begin
            err_d = 1'b1;
        end
    end

    // beat counter and sticky overrun flag
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign err_burst = err_q;
`else
    logic unused_cfg;

    assign limit_hit  = 1'b0;
    assign err_burst  = 1'b0;
    assign unused_cfg = (MAX_BEATS != 0);
`endif

endmodule

// File: tb/tb_myip23_mem_arbiter.sv
// Directed self-checking bench for myip23_mem_arbiter with a 1-cycle RAM model.
// Build with MEM_ARB_BURST_LIMIT_EN defined to exercise the 4-beat limit.
module tb_myip23_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 32;
`ifdef MEM_ARB_BURST_LIMIT_EN
    localparam int MB = 4;
`else
    localparam int MB = 256;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N-1:0]  req_we;
    logic [N-1:0]  req_last;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]  req_gnt;
    logic [N-1:0]  rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    owner_id;
    logic          err_burst;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    myip23_mem_arbiter #(
        .NUM_REQ    (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MEM_RD_LAT (1),
        .MAX_BEATS  (MB)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_last  (req_last),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_gnt   (req_gnt),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner_id  (owner_id),
        .err_burst (err_burst)
    );

    logic [DW-1:0] ram [1024];
    logic [DW-1:0] rdq = '0;

    always @(posedge clk) begin
        if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
        if (mem_en && !mem_we) rdq <= ram[mem_addr];
    end
    assign mem_rdata = rdq;

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic last, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_last[i]          = last;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_we    = '0;
        req_last  = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_reqs();
        rst_n = 1'b0;
        #3;
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_busy got=%0b exp=0", busy);
        end
        checks++;
        if (owner_id !== 2'd0) begin
            failures++; $display("FAIL reset_owner got=%0d exp=0", owner_id);
        end
        checks++;
        if (req_gnt !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=000", req_gnt);
        end
        checks++;
        if (rsp_valid !== 3'b000) begin
            failures++; $display("FAIL reset_rsp got=%b exp=000", rsp_valid);
        end
        checks++;
        if ({mem_en, mem_we} !== 2'b00) begin
            failures++; $display("FAIL reset_mem_en_we got=%b exp=00", {mem_en, mem_we});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL reset_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (err_burst !== 1'b0) begin
            failures++; $display("FAIL reset_err got=%0b exp=0", err_burst);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_write_burst();
        logic [DW-1:0] d;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 1'b0, 10'h000, 32'h11111111);
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b000 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL wr_bubble got gnt=%b en=%b exp=000/0", req_gnt, mem_en);
        end
        for (int b = 0; b < 4; b++) begin
            d = DW'(32'h11111111 * (b + 1));
            @(posedge clk); #1;
            set_req(0, 1'b1, 1'b1, (b == 3), AW'(b), d);
            @(negedge clk);
            checks++;
            if (req_gnt !== 3'b001) begin
                failures++; $display("FAIL wr_gnt b%0d got=%b exp=001", b, req_gnt);
            end
            checks++;
            if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
                failures++;
                $display("FAIL wr_en_we b%0d got=%b%b exp=11", b, mem_en, mem_we);
            end
            checks++;
            if (mem_addr !== AW'(b) || mem_wdata !== d) begin
                failures++;
                $display("FAIL wr_bus b%0d got=%h/%h exp=%h/%h",
                         b, mem_addr, mem_wdata, AW'(b), d);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++; $display("FAIL wr_busy b%0d got=%b exp=1", b, busy);
            end
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req_gnt !== 3'b000) begin
            failures++;
            $display("FAIL wr_end got busy=%b gnt=%b exp=0/000", busy, req_gnt);
        end
    endtask

    task automatic test_read_burst();
        logic [DW-1:0] e;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 1'b0, 10'h000, '0);
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b000) begin
            failures++; $display("FAIL rd_bubble got=%b exp=000", req_gnt);
        end
        for (int b = 0; b < 4; b++) begin
            @(posedge clk); #1;
            set_req(1, 1'b1, 1'b0, (b == 3), AW'(b), '0);
            @(negedge clk);
            checks++;
            if (req_gnt !== 3'b010 || mem_en !== 1'b1 || mem_we !== 1'b0 ||
                mem_addr !== AW'(b)) begin
                failures++;
                $display("FAIL rd_beat b%0d got gnt=%b en=%b we=%b a=%h exp=010/1/0/%h",
                         b, req_gnt, mem_en, mem_we, mem_addr, AW'(b));
            end
            e = DW'(32'h11111111 * b);
            checks++;
            if (b == 0) begin
                if (rsp_valid !== 3'b000) begin
                    failures++; $display("FAIL rd_rsp0 got=%b exp=000", rsp_valid);
                end
            end else if (rsp_valid !== 3'b010 || rsp_rdata !== e) begin
                failures++;
                $display("FAIL rd_rsp b%0d got=%b/%h exp=010/%h", b, rsp_valid, rsp_rdata, e);
            end
        end
        @(posedge clk); #1;
        set_req(1, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b010 || rsp_rdata !== 32'h44444444 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rd_rsp_last got=%b/%h busy=%b exp=010/44444444/0",
                     rsp_valid, rsp_rdata, busy);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b000) begin
            failures++; $display("FAIL rd_rsp_drain got=%b exp=000", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int log[$];
        int cnt[N];
        int got;
        int exp;
        do_reset();
        cnt = '{default: 0};
        set_req(0, 1'b1, 1'b1, 1'b0, 10'h200, 32'hA0A0A0A0);
        set_req(2, 1'b1, 1'b1, 1'b0, 10'h210, 32'hC2C2C2C2);
        for (int cyc = 0; cyc < 30 && log.size() < 8; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_gnt[i]) begin
                    log.push_back(i);
                    cnt[i]++;
                end
            end
            @(posedge clk); #1;
            req_last[0] = (cnt[0] % 2 == 1);
            req_last[2] = (cnt[2] % 2 == 1);
            if (log.size() >= 8) req_valid = '0;
        end
        req_valid = '0;
        checks++;
        if (log.size() != 8) begin
            failures++; $display("FAIL rr_count got=%0d exp=8", log.size());
        end
        for (int k = 0; k < 8; k++) begin
            got = (k < log.size()) ? log[k] : -1;
            exp = ((k / 2) % 2 == 0) ? 0 : 2;
            checks++;
            if (got != exp) begin
                failures++; $display("FAIL rr_order beat%0d got=%0d exp=%0d", k, got, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL rr_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 10'h300, 32'hDEAD0000);
        set_req(2, 1'b1, 1'b1, 1'b1, 10'h3F0, 32'hBEEF0002);
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b001 || mem_addr !== 10'h300) begin
            failures++;
            $display("FAIL st_first got=%b/%h exp=001/300", req_gnt, mem_addr);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            checks++;
            if (mem_en !== 1'b0 || req_gnt !== 3'b000 || busy !== 1'b1 ||
                owner_id !== 2'd0) begin
                failures++;
                $display("FAIL st_hold c%0d got en=%b gnt=%b busy=%b own=%0d exp=0/000/1/0",
                         s, mem_en, req_gnt, busy, owner_id);
            end
            @(posedge clk); #1;
        end
        set_req(0, 1'b1, 1'b1, 1'b1, 10'h301, 32'hDEAD0001);
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b001 || mem_addr !== 10'h301 || mem_en !== 1'b1) begin
            failures++;
            $display("FAIL st_resume got=%b/%h exp=001/301", req_gnt, mem_addr);
        end
        @(posedge clk); #1;
        set_req(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL st_bubble got gnt=%b busy=%b exp=000/0", req_gnt, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (req_gnt !== 3'b100 || owner_id !== 2'd2 || mem_addr !== 10'h3F0 ||
            mem_wdata !== 32'hBEEF0002) begin
            failures++;
            $display("FAIL st_next got gnt=%b own=%0d a=%h d=%h exp=100/2/3f0/beef0002",
                     req_gnt, owner_id, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        set_req(2, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL st_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_burst_limit();
        int  ngnt;
        int  beat;
        int  exp_n;
        logic exp_err;
        logic seen;
        logic done;
        logic gnow;
`ifdef MEM_ARB_BURST_LIMIT_EN
        exp_n   = 4;
        exp_err = 1'b1;
`else
        exp_n   = 6;
        exp_err = 1'b0;
`endif
        ngnt = 0;
        beat = 0;
        seen = 1'b0;
        done = 1'b0;
        do_reset();
        set_req(0, 1'b1, 1'b1, 1'b0, 10'h080, 32'h0000F000);
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            @(negedge clk);
            gnow = req_gnt[0];
            if (gnow) begin
                ngnt++;
                seen = 1'b1;
            end else if (seen) begin
                done = 1'b1;
                req_valid[0] = 1'b0;
            end
            if (!done) begin
                @(posedge clk); #1;
                if (gnow) beat++;
                set_req(0, 1'b1, 1'b1, (beat == 5), AW'(10'h080 + beat),
                        DW'(32'h0000F000 + beat));
            end
        end
        req_valid = '0;
        checks++;
        if (!done) begin
            failures++; $display("FAIL bl_timeout got=running exp=ended");
        end
        checks++;
        if (ngnt != exp_n) begin
            failures++; $display("FAIL bl_beats got=%0d exp=%0d", ngnt, exp_n);
        end
        checks++;
        if (err_burst !== exp_err) begin
            failures++; $display("FAIL bl_err got=%b exp=%b", err_burst, exp_err);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL bl_idle got busy=%b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(1, 1'b1, 1'b0, 1'b0, 10'h000, '0);
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_req(1, 1'b1, 1'b0, 1'b0, 10'h001, '0);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 3'b010) begin
            failures++; $display("FAIL rm_inflight got=%b exp=010", rsp_valid);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0 || req_gnt !== 3'b000) begin
            failures++;
            $display("FAIL rm_async got rsp=%b busy=%b gnt=%b exp=000/0/000",
                     rsp_valid, busy, req_gnt);
        end
        checks++;
        if (mem_en !== 1'b0 || owner_id !== 2'd0 || mem_addr !== '0) begin
            failures++;
            $display("FAIL rm_mem got en=%b own=%0d a=%h exp=0/0/0", mem_en, owner_id, mem_addr);
        end
        clear_reqs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rm_after c%0d got rsp=%b busy=%b exp=000/0", c, rsp_valid, busy);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_reqs();
        rst_n = 1'b0;
        test_reset();
        test_write_burst();
        test_read_burst();
        test_round_robin();
        test_stall();
        test_burst_limit();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
